// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    // Status flags gathered in one bundle for internal routing
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 1024;

    // Occupancy counter must represent 0..depth inclusive, hence one extra bit
    function automatic int unsigned calc_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: one write port, one registered read port, no reset
// so that synthesis can map it onto a RAM macro.
module fifo_mem_2p #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port; pointers never collide because a
    // read needs a non-empty FIFO and a write needs a non-full one.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, read-valid strobe and sticky errors.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     din,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = calc_cnt_w(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              dout_valid_q;
    logic              dout_seen_q;
    logic              overflow_q;
    logic              underflow_q;
    logic [DATA_W-1:0] mem_rdata;
    logic              wr_acc;
    logic              rd_acc;
    fifo_status_t      status_c;

    // Flags decoded straight from the registered count, no extra latency
    always_comb begin
        status_c              = '0;
        status_c.full         = (count_q == CNT_W'(DEPTH));
        status_c.empty        = (count_q == '0);
        status_c.almost_full  = (count_q >= CNT_W'(AF_THRESH));
        status_c.almost_empty = (count_q <= CNT_W'(AE_THRESH));
        status_c.overflow     = overflow_q;
        status_c.underflow    = underflow_q;
    end

    // Accept decisions use the flags as they stand at the start of the cycle
    always_comb begin
        wr_acc = wr_en & ~status_c.full;
        rd_acc = rd_en & ~status_c.empty;
    end

    // Pointers, occupancy, read strobe and sticky error bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_valid_q <= 1'b0;
            dout_seen_q  <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_q    <= rd_ptr_q + ADDR_W'(1);
                dout_seen_q <= 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            dout_valid_q <= rd_acc;
            // A new error event beats a clear issued in the same cycle
            overflow_q  <= (overflow_q  & ~clr_err) | (wr_en & status_c.full);
            underflow_q <= (underflow_q & ~clr_err) | (rd_en & status_c.empty);
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // RAM output is unreset; present zero until the first read after reset
    always_comb begin
        dout         = dout_seen_q ? mem_rdata : '0;
        dout_valid   = dout_valid_q;
        full         = status_c.full;
        empty        = status_c.empty;
        almost_full  = status_c.almost_full;
        almost_empty = status_c.almost_empty;
        count        = count_q;
        overflow     = status_c.overflow;
        underflow    = status_c.underflow;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=8).
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic [7:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(
        .DATA_W    (8),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of requests from a falling edge; return at the next falling edge
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = 8'h00;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-stream with five entries held
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("t1_pre_dout", 32'(dout), 32'h01);
        check("t1_pre_valid", 32'(dout_valid), 32'd1);
        check("t1_pre_count", 32'(count), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("t1_count", 32'(count), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_dout", 32'(dout), 32'd0);
        check("t1_valid", 32'(dout_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fill to full, then drain in order
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            check("t2_w_count", 32'(count), 32'(i));
            check("t2_w_full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
            check("t2_w_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
            check("t2_w_ae", 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
            check("t2_w_empty", 32'(empty), 32'd0);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("t2_r_dout", 32'(dout), 32'(i));
            check("t2_r_valid", 32'(dout_valid), 32'd1);
            check("t2_r_count", 32'(count), 32'(8 - i));
        end
        step(1'b0, 8'h00, 1'b0);
        check("t2_idle_valid", 32'(dout_valid), 32'd0);
        check("t2_idle_dout", 32'(dout), 32'h08);
        check("t2_empty", 32'(empty), 32'd1);

        // Write while full sets overflow until cleared
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_count", 32'(count), 32'd8);
        step(1'b0, 8'h00, 1'b0);
        check("t3_ovf_hold", 32'(overflow), 32'd1);
        clr_err = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        clr_err = 1'b0;
        check("t3_ovf_clr", 32'(overflow), 32'd0);

        // Full with simultaneous write+read: read wins, write rejected
        step(1'b1, 8'h55, 1'b1);
        check("t4_dout", 32'(dout), 32'h01);
        check("t4_valid", 32'(dout_valid), 32'd1);
        check("t4_count", 32'(count), 32'd7);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_full", 32'(full), 32'd0);
        for (int i = 2; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("t4_drain", 32'(dout), 32'(i));
        end
        check("t4_empty", 32'(empty), 32'd1);

        // Empty with simultaneous write+read: write wins, no fall-through
        step(1'b1, 8'h3C, 1'b1);
        check("t5_count", 32'(count), 32'd1);
        check("t5_unf", 32'(underflow), 32'd1);
        check("t5_valid", 32'(dout_valid), 32'd0);
        check("t5_dout", 32'(dout), 32'h08);
        step(1'b0, 8'h00, 1'b1);
        check("t5_rd_dout", 32'(dout), 32'h3C);
        check("t5_rd_valid", 32'(dout_valid), 32'd1);
        check("t5_rd_count", 32'(count), 32'd0);
        clr_err = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        clr_err = 1'b0;
        check("t5_unf_clr", 32'(underflow), 32'd0);
        check("t5_ovf_clr", 32'(overflow), 32'd0);

        // Steady streaming at occupancy 4 across pointer wrap
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        check("t6_pre_count", 32'(count), 32'd4);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h44 + i), 1'b1);
            check("t6_dout", 32'(dout), 32'(8'h40 + i));
            check("t6_valid", 32'(dout_valid), 32'd1);
            check("t6_count", 32'(count), 32'd4);
        end
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_unf", 32'(underflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("t6_tail", 32'(dout), 32'(8'h54 + i));
        end
        check("t6_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
